avalon_data_mem_responder: RTL and testbench

Avalon-MM slave data memory that answers the data-side master port of the MIPS CPU. It accepts word reads and byte-enabled writes and inserts a programmable number of wait states through `waitrequest`. Testbenches and the FPGA top-level use it as the data memory behind the CPU's avalon_bus wrapper, and it exercises the CPU's stall handling.

---
 rtl/avalon_data_mem_responder.sv | 105 ++++++++++
 tb/tb_avalon_data_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_data_mem_responder.sv
// Avalon-MM slave data memory with a fixed, parameterised number of wait states.
// It serves word reads and byte-enabled writes for the CPU's data-side master.
// Handshake: waitrequest = req & (state != ACK); the master holds address, read,
// write, byteenable and writedata while waitrequest is high; the transfer completes
// in the cycle waitrequest is low.
module avalon_data_mem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic [1:0]  state_dbg
);

  localparam int         AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            req;
  logic            in_range;
  logic            capture;
  logic [AW-1:0]   word_idx;
  logic            unused_addr_bits;
  logic [31:0]     mem [DEPTH_WORDS];

  assign req              = read | write;
  assign in_range         = {2'b00, address[31:2]} < 32'(DEPTH_WORDS);
  assign word_idx         = address[AW+1:2];
  assign unused_addr_bits = ^address[1:0];
  assign waitrequest      = req & (state != S_ACK);
  assign state_dbg        = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        // A dropped request mid-wait abandons the transfer without touching memory.
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data is latched on the edge entering ACK; simultaneous read+write is treated as a write.
  assign capture = read & ~write & (state != S_ACK) & (state_nxt == S_ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      readdata <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        readdata <= in_range ? mem[word_idx] : 32'h0000_0000;
      end
    end
  end

  // Memory has no reset; writes land on the edge leaving ACK.
  always_ff @(posedge clk) begin
    if (state == S_ACK && write && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          mem[word_idx][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_data_mem_responder.sv
// Directed and randomized checks of the Avalon data memory responder against a
// word-array model, across three wait-state configurations.
module tb_avalon_data_mem_responder;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [31:0] address    [3];
    logic        read       [3];
    logic        write      [3];
    logic [3:0]  byteenable [3];
    logic [31:0] writedata  [3];
    logic        waitrequest[3];
    logic [31:0] readdata   [3];
    logic [1:0]  state_dbg  [3];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [DEPTH];

    // Instance 0: 2 wait states, 16 words. Instance 1: 3 wait states. Instance 2: zero wait.
    avalon_data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .INIT_FILE("")) u_ws2 (
        .clk(clk), .reset(reset), .address(address[0]), .read(read[0]), .write(write[0]),
        .byteenable(byteenable[0]), .writedata(writedata[0]), .waitrequest(waitrequest[0]),
        .readdata(readdata[0]), .state_dbg(state_dbg[0]));

    avalon_data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
        .clk(clk), .reset(reset), .address(address[1]), .read(read[1]), .write(write[1]),
        .byteenable(byteenable[1]), .writedata(writedata[1]), .waitrequest(waitrequest[1]),
        .readdata(readdata[1]), .state_dbg(state_dbg[1]));

    avalon_data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
        .clk(clk), .reset(reset), .address(address[2]), .read(read[2]), .write(write[2]),
        .byteenable(byteenable[2]), .writedata(writedata[2]), .waitrequest(waitrequest[2]),
        .readdata(readdata[2]), .state_dbg(state_dbg[2]));

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // One full transfer, entered just after a rising edge with the DUT idle.
    task automatic xfer(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input int ws,
                        input string tag);
        int hi;
        bit done;
        logic [31:0] e;
        address[k] = addr; read[k] = rd; write[k] = wr; byteenable[k] = be; writedata[k] = wd;
        hi = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (waitrequest[k]) hi++;
            else begin
                done = 1'b1;
                if (rd && !wr) begin
                    e = exp_q.pop_front();
                    check({tag, "_rdata"}, readdata[k], e);
                end
            end
            @(posedge clk); #1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_wait_cycles"}, 32'(hi), 32'(ws + 1));
        read[k] = 1'b0;
        write[k] = 1'b0;
    endtask

    task automatic write_word(input int k, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input int ws, input string tag);
        xfer(k, 1'b0, 1'b1, addr, be, wd, ws, tag);
    endtask

    task automatic read_word(input int k, input logic [31:0] addr, input logic [31:0] exp,
                             input int ws, input string tag);
        exp_q.push_back(exp);
        xfer(k, 1'b1, 1'b0, addr, 4'h0, 32'h0, ws, tag);
    endtask

    function automatic logic [31:0] model_read(input int idx);
        return (idx < DEPTH) ? model_mem[idx] : 32'h0000_0000;
    endfunction

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            address[k] = '0; read[k] = 1'b0; write[k] = 1'b0;
            byteenable[k] = '0; writedata[k] = '0;
        end

        // Reset state
        #3;
        for (int k = 0; k < 3; k++) begin
            check("reset_readdata", readdata[k], 32'h0);
            check("reset_waitreq", 32'(waitrequest[k]), 32'd0);
            check("reset_state_idle", 32'(state_dbg[k]), 32'd0);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Fill instance 0 with known random contents
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = $urandom;
            write_word(0, 32'(i) << 2, 4'hF, model_mem[i], 2, "fill");
        end

        // Basic write then read
        write_word(0, 32'h10, 4'hF, 32'hCAFEBABE, 2, "basic_wr");
        model_mem[4] = 32'hCAFEBABE;
        read_word(0, 32'h10, 32'hCAFEBABE, 2, "basic_rd");

        // Byte lanes
        write_word(0, 32'h20, 4'hF, 32'h11223344, 2, "lanes_init");
        write_word(0, 32'h20, 4'b0101, 32'hAABBCCDD, 2, "lanes_wr");
        model_mem[8] = 32'h11BB33DD;
        read_word(0, 32'h20, 32'h11BB33DD, 2, "lanes_rd");

        // Out of range
        write_word(0, 32'h40, 4'hF, 32'hFFFF_FFFF, 2, "oor_wr");
        read_word(0, 32'h40, 32'h0, 2, "oor_rd");
        for (int i = 0; i < DEPTH; i++) read_word(0, 32'(i) << 2, model_mem[i], 2, "oor_intact");

        // Abort: write raised for one cycle then dropped while waiting
        address[0] = 32'h8; writedata[0] = $urandom; byteenable[0] = 4'hF; write[0] = 1'b1;
        @(negedge clk);
        check("abort_waitreq_hi", 32'(waitrequest[0]), 32'd1);
        @(posedge clk); #1;
        write[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_state_idle", 32'(state_dbg[0]), 32'd0);
        check("abort_waitreq_lo", 32'(waitrequest[0]), 32'd0);
        @(posedge clk); #1;
        read_word(0, 32'h8, model_mem[2], 2, "abort_rd");

        // Randomized mix of reads, writes and read+write
        for (int n = 0; n < 60; n++) begin
            int idx;
            int op;
            logic [31:0] addr;
            logic [3:0] be;
            logic [31:0] wd;
            idx  = $urandom_range(0, 19);
            op   = $urandom_range(0, 3);
            addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            be   = 4'($urandom_range(1, 15));
            wd   = $urandom;
            if (op <= 1) begin
                read_word(0, addr, model_read(idx), 2, "rand_rd");
            end else begin
                xfer(0, op == 3, 1'b1, addr, be, wd, 2, "rand_wr");
                if (idx < DEPTH) model_mem[idx] = merge(model_mem[idx], wd, be);
            end
        end
        for (int i = 0; i < DEPTH; i++) read_word(0, 32'(i) << 2, model_mem[i], 2, "rand_final");

        // Zero wait states with a held read
        write_word(2, 32'h0, 4'hF, 32'h5A5A0001, 0, "zw_wr");
        address[2] = 32'h0; read[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("zw_toggle", 32'(waitrequest[2]), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 1) check("zw_rdata", readdata[2], 32'h5A5A0001);
            @(posedge clk); #1;
        end
        read[2] = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a 3-wait-state write
        write_word(1, 32'hC, 4'hF, 32'h12345678, 3, "rst_pre_wr");
        read_word(1, 32'hC, 32'h12345678, 3, "rst_pre_rd");
        address[1] = 32'hC; writedata[1] = 32'hDEADBEEF; byteenable[1] = 4'hF; write[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_readdata", readdata[1], 32'h0);
        check("rst_readdata_other", readdata[0], 32'h0);
        check("rst_state_idle", 32'(state_dbg[1]), 32'd0);
        check("rst_waitreq_follows_req", 32'(waitrequest[1]), 32'd1);
        @(negedge clk); reset = 1'b1;
        #1;
        check("rst_release_idle", 32'(state_dbg[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_waitreq_again", 32'(waitrequest[1]), 32'd1);
        @(posedge clk); #1;
        write[1] = 1'b0;
        @(posedge clk); #1;
        read_word(1, 32'hC, 32'h12345678, 3, "rst_word_intact");
        read_word(0, 32'h10, model_mem[4], 2, "rst_mem_persist");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
